io_ctrl: RTL and testbench

IO_CTRL -- requirements
Module: io_ctrl

---
 rtl/io_ctrl_pkg.sv | 61 ++++++
 rtl/io_ctrl_sw_debounce.sv | 83 ++++++++
 rtl/io_ctrl.sv | 132 +++++++++++++
 tb/tb_io_ctrl.sv | 301 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/io_ctrl_pkg.sv
// io_pkg: shared address map, access classification and byte-merge helper
// for the io_ctrl register block.
//
// Contents:
//   ADDR_*         word addresses of the memory-mapped registers
//   access_t       classification of one access (LEDR/LEDG/HEX/LCD/SW/BAD)
//   decode_access  maps {addr, we, NUM_HEX} to an access_t
//   byte_merge     applies a 4-bit byte-enable mask to a 32-bit word
package io_pkg;

  localparam logic [11:0] ADDR_LEDR = 12'h000;
  localparam logic [11:0] ADDR_LEDG = 12'h010;
  localparam logic [11:0] ADDR_HEX  = 12'h020;
  localparam logic [11:0] ADDR_LCD  = 12'h030;
  localparam logic [11:0] ADDR_SW   = 12'h100;

  // HEX digits are 7 bits wide; bit 7 of every byte is never stored.
  localparam logic [31:0] HEX_BYTE_MASK = 32'h7F7F_7F7F;

  typedef enum logic [2:0] {
    ACC_LEDR,
    ACC_LEDG,
    ACC_HEX,
    ACC_LCD,
    ACC_SW,
    ACC_BAD
  } access_t;

  // Writes to SW and HEX words past the configured digit count are BAD.
  function automatic access_t decode_access(input logic [11:2] word,
                                            input logic        we,
                                            input int unsigned num_hex);
    logic [11:0] a;
    access_t     acc;
    a   = {word, 2'b00};
    acc = ACC_BAD;
    if (a == ADDR_LEDR)
      acc = ACC_LEDR;
    else if (a == ADDR_LEDG)
      acc = ACC_LEDG;
    else if ((a[11:4] == ADDR_HEX[11:4]) && (32'(a[3:2]) < (num_hex / 4)))
      acc = ACC_HEX;
    else if (a == ADDR_LCD)
      acc = ACC_LCD;
    else if ((a == ADDR_SW) && !we)
      acc = ACC_SW;
    return acc;
  endfunction

  function automatic logic [31:0] byte_merge(input logic [31:0] old_w,
                                             input logic [31:0] new_w,
                                             input logic [3:0]  mask);
    logic [31:0] m;
    m[7:0]   = mask[0] ? new_w[7:0]   : old_w[7:0];
    m[15:8]  = mask[1] ? new_w[15:8]  : old_w[15:8];
    m[23:16] = mask[2] ? new_w[23:16] : old_w[23:16];
    m[31:24] = mask[3] ? new_w[31:24] : old_w[31:24];
    return m;
  endfunction

endpackage

// File: rtl/io_ctrl_sw_debounce.sv
// sw_debounce: 2-flop synchroniser plus optional stability debouncer for a
// vector of asynchronous switch inputs.
//
// Configuration macro: IO_CTRL_DEBOUNCE_EN
//   defined   -> a change is accepted after the synchronised vector has been
//                stable (and different from the accepted value) for
//                DEBOUNCE_CYCLES consecutive cycles
//   undefined -> the synchronised vector is accepted every cycle
//
// Ports:
//   i_clk, i_reset  clock, synchronous active-high reset
//   i_sw   [W-1:0]  asynchronous inputs
//   o_sw   [W-1:0]  accepted (debounced) value, registered
//   o_evt           one-cycle pulse when o_sw changes
module sw_debounce #(
  parameter int unsigned WIDTH           = 32,
  parameter int unsigned DEBOUNCE_CYCLES = 16
) (
  input  logic             i_clk,
  input  logic             i_reset,
  input  logic [WIDTH-1:0] i_sw,
  output logic [WIDTH-1:0] o_sw,
  output logic             o_evt
);

  logic [WIDTH-1:0] r_meta;
  logic [WIDTH-1:0] r_sync;
  logic [WIDTH-1:0] r_deb;
  logic             r_evt;

`ifdef IO_CTRL_DEBOUNCE_EN
  localparam int unsigned CW = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic [WIDTH-1:0] r_prev;
  logic [CW-1:0]    r_cnt;

  // The terminal count loads and clears instead of incrementing, so the
  // counter can never exceed DEBOUNCE_CYCLES-1 and never wraps.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_meta <= '0;
      r_sync <= '0;
      r_prev <= '0;
      r_deb  <= '0;
      r_cnt  <= '0;
      r_evt  <= 1'b0;
    end else begin
      r_meta <= i_sw;
      r_sync <= r_meta;
      r_prev <= r_sync;
      r_evt  <= 1'b0;
      if ((r_sync != r_prev) || (r_sync == r_deb)) begin
        r_cnt <= '0;
      end else if (r_cnt == CNT_LAST) begin
        r_deb <= r_sync;
        r_cnt <= '0;
        r_evt <= 1'b1;
      end else begin
        r_cnt <= r_cnt + 1'b1;
      end
    end
  end
`else
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_meta <= '0;
      r_sync <= '0;
      r_deb  <= '0;
      r_evt  <= 1'b0;
    end else begin
      r_meta <= i_sw;
      r_sync <= r_meta;
      r_deb  <= r_sync;
      r_evt  <= (r_sync != r_deb);
    end
  end
`endif

  assign o_sw  = r_deb;
  assign o_evt = r_evt;

endmodule

// File: rtl/io_ctrl.sv
// io_ctrl: memory-mapped I/O register block (LEDs, 7-segment digits, LCD
// word, debounced switches) with a single-cycle request/ack bus.
//
// Configuration macro: IO_CTRL_DEBOUNCE_EN (see sw_debounce)
//
// Ports:
//   i_clk, i_reset        clock, synchronous active-high reset
//   i_req/i_we/i_addr     access request, write flag, byte address
//   i_wdata/i_bmask       write data and byte enables
//   i_io_sw   [31:0]      asynchronous switch inputs
//   o_ack                 completion pulse, one cycle after each request
//   o_rdata   [31:0]      read data (0 for writes and errors)
//   o_err                 unmapped/illegal access flag
//   o_io_ledr/ledg/lcd    register contents
//   o_io_hex  [7*N-1:0]   digit k on bits [7k+6:7k]
//   o_sw_evt              pulse on debounced switch change
module io_ctrl
  import io_pkg::*;
#(
  parameter int unsigned NUM_HEX         = 8,
  parameter int unsigned DEBOUNCE_CYCLES = 16
) (
  input  logic                 i_clk,
  input  logic                 i_reset,
  input  logic                 i_req,
  input  logic                 i_we,
  input  logic [11:0]          i_addr,
  input  logic [31:0]          i_wdata,
  input  logic [3:0]           i_bmask,
  input  logic [31:0]          i_io_sw,
  output logic                 o_ack,
  output logic [31:0]          o_rdata,
  output logic                 o_err,
  output logic [31:0]          o_io_ledr,
  output logic [31:0]          o_io_ledg,
  output logic [31:0]          o_io_lcd,
  output logic [7*NUM_HEX-1:0] o_io_hex,
  output logic                 o_sw_evt
);

  localparam int unsigned HEX_WORDS = NUM_HEX / 4;

  logic [31:0] r_ledr;
  logic [31:0] r_ledg;
  logic [31:0] r_lcd;
  logic        r_ack;
  logic        r_err;
  logic [31:0] r_rdata;

  logic [31:0]                w_sw_deb;
  logic                       w_sw_evt;
  access_t                    w_acc;
  logic                       w_hex_wr;
  logic [HEX_WORDS:0][31:0]   w_hex_or;
  logic                       w_unused_addr;

  assign w_unused_addr = ^i_addr[1:0];

  sw_debounce #(
    .WIDTH          (32),
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_sw_debounce (
    .i_clk  (i_clk),
    .i_reset(i_reset),
    .i_sw   (i_io_sw),
    .o_sw   (w_sw_deb),
    .o_evt  (w_sw_evt)
  );

  assign w_acc    = decode_access(i_addr[11:2], i_we, NUM_HEX);
  assign w_hex_wr = i_req && i_we && (w_acc == ACC_HEX);

  // Each HEX word is its own register; the read mux is an OR chain of the
  // selected word so no variable index into the word array is needed.
  assign w_hex_or[0] = '0;
  for (genvar j = 0; j < HEX_WORDS; j++) begin : g_hex
    logic [31:0] r_word;
    logic        w_hit;

    assign w_hit = (i_addr[3:2] == 2'(j));

    always_ff @(posedge i_clk) begin
      if (i_reset)
        r_word <= '0;
      else if (w_hex_wr && w_hit)
        r_word <= byte_merge(r_word, i_wdata, i_bmask) & HEX_BYTE_MASK;
    end

    assign w_hex_or[j+1] = w_hex_or[j] | (w_hit ? r_word : '0);

    for (genvar d = 0; d < 4; d++) begin : g_digit
      assign o_io_hex[7*(4*j+d) +: 7] = r_word[8*d +: 7];
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_ledr  <= '0;
      r_ledg  <= '0;
      r_lcd   <= '0;
      r_ack   <= 1'b0;
      r_err   <= 1'b0;
      r_rdata <= '0;
    end else begin
      r_ack   <= i_req;
      r_err   <= 1'b0;
      r_rdata <= '0;
      if (i_req) begin
        case (w_acc)
          ACC_LEDR: if (i_we) r_ledr <= byte_merge(r_ledr, i_wdata, i_bmask);
                    else      r_rdata <= r_ledr;
          ACC_LEDG: if (i_we) r_ledg <= byte_merge(r_ledg, i_wdata, i_bmask);
                    else      r_rdata <= r_ledg;
          ACC_LCD:  if (i_we) r_lcd <= byte_merge(r_lcd, i_wdata, i_bmask);
                    else      r_rdata <= r_lcd;
          ACC_HEX:  if (!i_we) r_rdata <= w_hex_or[HEX_WORDS];
          ACC_SW:   r_rdata <= w_sw_deb;
          default:  r_err <= 1'b1;
        endcase
      end
    end
  end

  assign o_ack     = r_ack;
  assign o_err     = r_err;
  assign o_rdata   = r_rdata;
  assign o_io_ledr = r_ledr;
  assign o_io_ledg = r_ledg;
  assign o_io_lcd  = r_lcd;
  assign o_sw_evt  = w_sw_evt;

endmodule

// File: tb/tb_io_ctrl.sv
// Testbench for io_ctrl: directed steps plus randomized traffic checked
// against a behavioural model of the register map and switch filter.
module tb_io_ctrl;

  localparam int unsigned NH = 8;
  localparam int unsigned DC = 6;
`ifdef IO_CTRL_DEBOUNCE_EN
  localparam int EXP_LAT = 2 + DC;
`else
  localparam int EXP_LAT = 2;
`endif

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset, req, req4, we;
  logic [11:0] addr;
  logic [31:0] wdata, sw;
  logic [3:0]  bmask;

  logic          ack, err, evt;
  logic [31:0]   rdata, ledr, ledg, lcd;
  logic [7*NH-1:0] hex;
  logic          ack4, err4, evt4;
  logic [31:0]   rdata4, ledr4, ledg4, lcd4;
  logic [27:0]   hex4;

  io_ctrl #(.NUM_HEX(NH), .DEBOUNCE_CYCLES(DC)) u_dut8 (
    .i_clk(clk), .i_reset(reset), .i_req(req), .i_we(we), .i_addr(addr),
    .i_wdata(wdata), .i_bmask(bmask), .i_io_sw(sw), .o_ack(ack),
    .o_rdata(rdata), .o_err(err), .o_io_ledr(ledr), .o_io_ledg(ledg),
    .o_io_lcd(lcd), .o_io_hex(hex), .o_sw_evt(evt));

  io_ctrl #(.NUM_HEX(4), .DEBOUNCE_CYCLES(DC)) u_dut4 (
    .i_clk(clk), .i_reset(reset), .i_req(req4), .i_we(we), .i_addr(addr),
    .i_wdata(wdata), .i_bmask(bmask), .i_io_sw(sw), .o_ack(ack4),
    .o_rdata(rdata4), .o_err(err4), .o_io_ledr(ledr4), .o_io_ledg(ledg4),
    .o_io_lcd(lcd4), .o_io_hex(hex4), .o_sw_evt(evt4));

  // Reference model state
  logic [31:0] m_ledr, m_ledg, m_lcd, m_deb, m_rdata, m_rdata4;
  logic [31:0] m_hex [NH/4];
  logic        m_ack, m_err, m_evt, m_ack4, m_err4, m_chk4;
  logic [31:0] hist [$];   // switch input sampled at each clock edge

  int unsigned n_pass = 0;
  int unsigned n_total = 0;
  int unsigned n_fail = 0;

  // 0 LEDR, 1 LEDG, 2 HEX, 3 LCD, 4 SW read, 5 error
  function automatic int ref_kind(input logic [11:0] a, input logic w,
                                  input int unsigned nh);
    int unsigned off;
    off = {20'b0, a[11:2], 2'b00};
    if (off == 0) return 0;
    if (off == 16) return 1;
    if (off >= 32 && off < 32 + nh) return 2;
    if (off == 48) return 3;
    if (off == 256) return w ? 5 : 4;
    return 5;
  endfunction

  function automatic logic [31:0] merge(input logic [31:0] o,
                                        input logic [31:0] n,
                                        input logic [3:0] m);
    logic [31:0] r;
    r = o;
    for (int b = 0; b < 4; b++)
      if (m[b]) r[8*b +: 8] = n[8*b +: 8];
    return r;
  endfunction

  function automatic logic [7*NH-1:0] model_hex();
    logic [7*NH-1:0] h;
    for (int k = 0; k < int'(NH); k++)
      h[7*k +: 7] = m_hex[k/4][8*(k%4) +: 7];
    return h;
  endfunction

  task automatic clear_hist();
    hist.delete();
    for (int i = 0; i < int'(DC) + 3; i++) hist.push_back(32'h0);
  endtask

  task automatic model_step();
    int kind, idx, n;
    logic all_eq;
    logic [31:0] v;
    if (reset) begin
      m_ledr = 0; m_ledg = 0; m_lcd = 0; m_deb = 0; m_rdata = 0;
      for (int j = 0; j < int'(NH/4); j++) m_hex[j] = 0;
      m_ack = 0; m_err = 0; m_evt = 0;
      m_ack4 = 0; m_err4 = 0; m_rdata4 = 0; m_chk4 = 0;
      clear_hist();
    end else begin
      m_ack = req; m_err = 0; m_rdata = 0;
      if (req) begin
        kind = ref_kind(addr, we, NH);
        case (kind)
          0: if (we) m_ledr = merge(m_ledr, wdata, bmask); else m_rdata = m_ledr;
          1: if (we) m_ledg = merge(m_ledg, wdata, bmask); else m_rdata = m_ledg;
          2: begin
            idx = (int'({addr[11:2], 2'b00}) - 32) / 4;
            if (we) m_hex[idx] = merge(m_hex[idx], wdata, bmask) & 32'h7F7F7F7F;
            else m_rdata = m_hex[idx];
          end
          3: if (we) m_lcd = merge(m_lcd, wdata, bmask); else m_rdata = m_lcd;
          4: m_rdata = m_deb;
          default: m_err = 1;
        endcase
      end
      m_ack4 = req4; m_chk4 = req4; m_err4 = 0; m_rdata4 = 0;
      if (req4) begin
        kind = ref_kind(addr, we, 4);
        if (kind == 5) m_err4 = 1;
        else if (kind == 4) m_rdata4 = m_deb;
        else m_chk4 = 0;
      end
      // Switch path: input at edge k reaches the filter two edges later.
      n = hist.size();
      v = hist[n-2];
      m_evt = 0;
`ifdef IO_CTRL_DEBOUNCE_EN
      all_eq = 1;
      for (int i = n - 2 - int'(DC); i <= n - 2; i++)
        if (hist[i] != v) all_eq = 0;
      if (all_eq && v != m_deb) begin
        m_deb = v;
        m_evt = 1;
      end
`else
      all_eq = 0;
      m_evt = (v != m_deb) | all_eq;
      m_deb = v;
`endif
      hist.push_back(sw);
      void'(hist.pop_front());
    end
  endtask

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic check_all();
    chk("ack", 64'(ack), 64'(m_ack));
    chk("err", 64'(err), 64'(m_err));
    chk("rdata", 64'(rdata), 64'(m_rdata));
    chk("ledr", 64'(ledr), 64'(m_ledr));
    chk("ledg", 64'(ledg), 64'(m_ledg));
    chk("lcd", 64'(lcd), 64'(m_lcd));
    chk("hex", 64'(hex), 64'(model_hex()));
    chk("sw_evt", 64'(evt), 64'(m_evt));
    chk("ack4", 64'(ack4), 64'(m_ack4));
    if (m_chk4) begin
      chk("err4", 64'(err4), 64'(m_err4));
      chk("rdata4", 64'(rdata4), 64'(m_rdata4));
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
    check_all();
  endtask

  function automatic logic [11:0] rand_addr();
    logic [11:0] tbl [8];
    tbl = '{12'h000, 12'h010, 12'h020, 12'h024, 12'h030, 12'h100, 12'h004, 12'h02C};
    if ($urandom_range(0, 4) == 0) return 12'($urandom);
    return tbl[$urandom_range(0, 7)] | 12'($urandom_range(0, 3));
  endfunction

  initial begin
    int hold_left;
    int evt_cnt, evt_at, acks;
    logic [27:0] hslice;

    reset = 1; req = 0; req4 = 0; we = 0; addr = 0; wdata = 0; bmask = 0; sw = 0;
    clear_hist();
    tick(); tick();
    chk("reset_ledr", 64'(ledr), 64'h0);
    chk("reset_ack", 64'(ack), 64'h0);

    // Request on the first cycle out of reset; partial byte write then read.
    reset = 0;
    req = 1; we = 1; addr = 12'h000; wdata = 32'hDEADBEEF; bmask = 4'b0101;
    tick();
    chk("wr_ack", 64'(ack), 64'h1);
    we = 0;
    tick();
    chk("rd_partial", 64'(rdata), 64'h00AD00EF);
    req = 0;
    tick();
    chk("ack_drops", 64'(ack), 64'h0);

    // HEX word 1 carries digits 4..7.
    req = 1; we = 1; addr = 12'h024; wdata = 32'h7F3F067F; bmask = 4'hF;
    tick();
    hslice = hex[55:28];
    chk("hex_digits", 64'(hslice), 64'({7'h7F, 7'h3F, 7'h06, 7'h7F}));
    // bmask=0 write completes without error and changes nothing
    addr = 12'h010; wdata = 32'hFFFFFFFF; bmask = 4'h0;
    tick();
    chk("bmask0_err", 64'(err), 64'h0);
    req = 0;

    // Four-digit instance: HEX word 1 is unmapped, SW is read-only.
    req4 = 1; we = 0; addr = 12'h024;
    tick();
    chk("n4_hex1_err", 64'(err4), 64'h1);
    chk("n4_hex1_rdata", 64'(rdata4), 64'h0);
    we = 1; addr = 12'h100; wdata = 32'h12345678; bmask = 4'hF;
    tick();
    chk("n4_swwr_err", 64'(err4), 64'h1);
    we = 0;
    tick();
    chk("n4_sw_unchanged", 64'(rdata4), 64'h0);
    req4 = 0;
    tick();

    // Back-to-back accesses
    acks = 0;
    for (int i = 0; i < 5; i++) begin
      req = 1; we = 1'($urandom); addr = rand_addr(); wdata = $urandom;
      bmask = 4'($urandom);
      tick();
      if (ack) acks++;
    end
    req = 0;
    tick();
    chk("b2b_acks", 64'(acks), 64'd5);

    // Randomized traffic with switch values held for random lengths.
    hold_left = 0;
    for (int i = 0; i < 400; i++) begin
      req = ($urandom_range(0, 3) != 0); we = 1'($urandom);
      addr = rand_addr(); wdata = $urandom; bmask = 4'($urandom);
      if (hold_left == 0) begin
        case ($urandom_range(0, 3))
          0: sw = 32'h0;
          1: sw = 32'h8;
          2: sw = 32'hFFFFFFFF;
          default: sw = $urandom;
        endcase
        hold_left = $urandom_range(1, int'(DC) + 4);
      end else hold_left--;
      tick();
    end

    // Glitching bit 3 then a steady hold; SW read every cycle.
    req = 1; we = 0; addr = 12'h100; sw = 0;
    for (int i = 0; i < int'(DC) + 6; i++) tick();
    for (int i = 0; i < 10; i++) begin
      sw = (i % 2 == 0) ? 32'h8 : 32'h0;
      tick();
    end
    sw = 32'h8;
    evt_cnt = 0; evt_at = -1;
    for (int k = 0; k <= int'(DC) + 6; k++) begin
      tick();
      if (k >= 2 && evt) begin
        evt_cnt++;
        evt_at = k;
      end
      if (k == EXP_LAT) chk("sw_pre_update", 64'(rdata), 64'h0);
      if (k == EXP_LAT + 1) chk("sw_post_update", 64'(rdata), 64'h8);
    end
    chk("sw_evt_count", 64'(evt_cnt), 64'd1);
    chk("sw_evt_latency", 64'(evt_at), 64'(EXP_LAT));

    // Reset in the middle of a request stream.
    for (int i = 0; i < 3; i++) begin
      req = 1; we = 1; addr = rand_addr(); wdata = $urandom; bmask = 4'hF;
      tick();
    end
    reset = 1; req = 1; we = 1; addr = 12'h000; wdata = 32'hA5A5A5A5;
    tick();
    chk("rst_ack", 64'(ack), 64'h0);
    chk("rst_ledr", 64'(ledr), 64'h0);
    chk("rst_hex", 64'(hex), 64'h0);
    chk("rst_rdata", 64'(rdata), 64'h0);
    reset = 0; we = 0; addr = 12'h000;
    tick();
    chk("post_rst_ack", 64'(ack), 64'h1);
    chk("post_rst_rd", 64'(rdata), 64'h0);
    req = 0;
    tick();

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
